// File: rtl/axis_video_pkg.sv
// Shared constants for the AXI-Stream video frame checker: default raster size,
// FSM encoding, error bit positions and the backpressure LFSR definition.
package axis_video_pkg;

    localparam int DEF_H_ACTIVE = 1920;
    localparam int DEF_V_ACTIVE = 1080;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    localparam int ERR_SHORT_LINE  = 0;
    localparam int ERR_LONG_LINE   = 1;
    localparam int ERR_EARLY_SOF   = 2;
    localparam int ERR_SOF_MISSING = 3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 in right-shifting form: feedback is the XOR of bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {^(q & LFSR_TAPS), q[15:1]};
    endfunction

endpackage

// File: rtl/axis_video_chk_if.sv
// AXI-Stream video beat bundle between a pixel source and the frame checker.
// The source owns data/valid/user/last; the checker owns ready.
interface axis_video_chk_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic              s_tuser;
    logic              s_tlast;

    modport master (
        output s_tdata,
        output s_tvalid,
        output s_tuser,
        output s_tlast,
        input  s_tready
    );

    modport slave (
        input  s_tdata,
        input  s_tvalid,
        input  s_tuser,
        input  s_tlast,
        output s_tready
    );
endinterface

// File: rtl/axis_bp_lfsr.sv
// 16-bit Fibonacci LFSR used as a pseudo-random backpressure source.
// One step per enabled cycle; no handshake.
module axis_bp_lfsr
    import axis_video_pkg::*;
(
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        en,
    output logic [15:0] q
);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/axis_video_chk.sv
// Video stream checker: counts beats/lines, flags framing errors, reports frames.
// Status updates one cycle after the deciding beat; s_tready is registered (LFSR-gated when bp_en).
module axis_video_chk
    import axis_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int DATA_W   = 24
) (
    input  logic              clk_in,
    input  logic              reset_n,
    axis_video_chk_if.slave   s,
    input  logic              bp_en,
    input  logic              clr_err,
    output logic              frame_done,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       last_line_len,
    output logic [15:0]       last_frame_lines,
    output logic [3:0]        err_flags
);

    localparam logic [16:0] H_LIM = 17'(H_ACTIVE);
    localparam logic [16:0] H_END = 17'(H_ACTIVE) + 17'd1;
    localparam logic [16:0] V_END = 17'(V_ACTIVE);

    state_t            state;
    logic [15:0]       pix_cnt;
    logic [15:0]       line_cnt;
    logic              gap_seen;
    logic [DATA_W-1:0] last_tdata;
    logic [15:0]       lfsr_q;

    logic              beat;
    logic              accept;
    logic              sof;
    logic [15:0]       pix_base;
    logic [15:0]       line_base;
    logic [16:0]       pix_sum;
    logic [15:0]       pix_next;
    logic [16:0]       line_sum;
    logic [3:0]        err_set;
    logic              unused_bits;

    axis_bp_lfsr u_lfsr (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .en      (1'b1),
        .q       (lfsr_q)
    );

    assign unused_bits = ^{lfsr_q[15:1], last_tdata};

    // A tuser beat always starts counting from a fresh frame, whatever state we are in.
    always_comb begin
        beat      = s.s_tvalid & s.s_tready;
        sof       = beat & s.s_tuser;
        accept    = beat & (s.s_tuser | (state == IN_FRAME));
        pix_base  = sof ? 16'd0 : pix_cnt;
        line_base = sof ? 16'd0 : line_cnt;
        pix_sum   = {1'b0, pix_base} + 17'd1;
        pix_next  = pix_sum[16] ? 16'hFFFF : pix_sum[15:0];
        line_sum  = {1'b0, line_base} + 17'd1;
        err_set   = '0;
        if (beat && (state == WAIT_SOF) && !s.s_tuser && !gap_seen) begin
            err_set[ERR_SOF_MISSING] = 1'b1;
        end
        if (beat && (state == IN_FRAME) && s.s_tuser) begin
            err_set[ERR_EARLY_SOF] = 1'b1;
        end
        if (accept && (pix_sum == H_END)) begin
            err_set[ERR_LONG_LINE] = 1'b1;
        end
        if (accept && s.s_tlast && (pix_sum < H_LIM)) begin
            err_set[ERR_SHORT_LINE] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state            <= WAIT_SOF;
            s.s_tready       <= 1'b0;
            frame_done       <= 1'b0;
            frame_cnt        <= '0;
            last_line_len    <= '0;
            last_frame_lines <= '0;
            err_flags        <= '0;
            pix_cnt          <= '0;
            line_cnt         <= '0;
            gap_seen         <= 1'b0;
            last_tdata       <= '0;
        end else begin
            frame_done <= 1'b0;
            s.s_tready <= bp_en ? lfsr_q[0] : 1'b1;
            err_flags  <= (clr_err ? 4'd0 : err_flags) | err_set;

            if (beat) begin
                last_tdata <= s.s_tdata;
            end
            if (beat && (state == WAIT_SOF) && !s.s_tuser) begin
                gap_seen <= 1'b1;
            end

            if (accept) begin
                gap_seen <= 1'b0;
                state    <= IN_FRAME;
                line_cnt <= line_base;
                if ((state == IN_FRAME) && s.s_tuser) begin
                    last_frame_lines <= line_cnt;
                end
                if (s.s_tlast) begin
                    last_line_len <= pix_next;
                    pix_cnt       <= '0;
                    line_cnt      <= line_sum[15:0];
                    if (line_sum == V_END) begin
                        frame_done       <= 1'b1;
                        frame_cnt        <= frame_cnt + 16'd1;
                        last_frame_lines <= 16'(V_ACTIVE);
                        line_cnt         <= '0;
                        state            <= WAIT_SOF;
                    end
                end else begin
                    pix_cnt <= pix_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_video_chk.sv
// Directed bench for axis_video_chk on an 8x4 raster with hand-computed expectations.
module tb_axis_video_chk;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int DW = 24;

    logic        clk_in  = 1'b0;
    logic        reset_n = 1'b1;
    logic        bp_en   = 1'b0;
    logic        clr_err = 1'b0;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic [15:0] last_line_len;
    logic [15:0] last_frame_lines;
    logic [3:0]  err_flags;

    int checks   = 0;
    int failures = 0;
    int fd_total = 0;

    logic [15:0] m;
    logic        exp_rdy;

    axis_video_chk_if #(.DATA_W(DW)) vif ();

    axis_video_chk #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .DATA_W   (DW)
    ) dut (
        .clk_in           (clk_in),
        .reset_n          (reset_n),
        .s                (vif),
        .bp_en            (bp_en),
        .clr_err          (clr_err),
        .frame_done       (frame_done),
        .frame_cnt        (frame_cnt),
        .last_line_len    (last_line_len),
        .last_frame_lines (last_frame_lines),
        .err_flags        (err_flags)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (frame_done === 1'b1) fd_total <= fd_total + 1;
    end

    // Reference backpressure: bit 0 of the taps-16/14/13/11 LFSR, registered once.
    always @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            m       <= 16'hACE1;
            exp_rdy <= 1'b0;
        end else begin
            exp_rdy <= bp_en ? m[0] : 1'b1;
            m       <= {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        vif.s_tvalid = 1'b0;
        vif.s_tuser  = 1'b0;
        vif.s_tlast  = 1'b0;
        clr_err      = 1'b0;
        reset_n      = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic send_beat(input logic user, input logic last);
        bit ok = 1'b0;
        vif.s_tvalid = 1'b1;
        vif.s_tuser  = user;
        vif.s_tlast  = last;
        vif.s_tdata  = DW'($urandom);
        for (int i = 0; i < 64 && !ok; i++) begin
            ok = vif.s_tready;
            tick(1);
        end
        vif.s_tvalid = 1'b0;
        vif.s_tuser  = 1'b0;
        vif.s_tlast  = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL beat_timeout ready not seen within 64 cycles");
        end
    endtask

    task automatic send_line(input int len, input bit first_sof);
        for (int i = 0; i < len; i++) send_beat(first_sof && (i == 0), i == len - 1);
    endtask

    task automatic send_frame();
        for (int l = 0; l < V; l++) send_line(H, l == 0);
    endtask

    task automatic test_reset();
        vif.s_tvalid = 1'b0;
        vif.s_tuser  = 1'b0;
        vif.s_tlast  = 1'b0;
        vif.s_tdata  = '0;
        reset_n = 1'b0;
        tick(2);
        checks++;
        if (vif.s_tready !== 1'b0) begin
            failures++; $display("FAIL reset_tready got=%b exp=0", vif.s_tready);
        end
        checks++;
        if ({frame_done, frame_cnt, last_line_len, last_frame_lines, err_flags} !== 53'd0) begin
            failures++;
            $display("FAIL reset_outputs got fd=%b fc=%0d lll=%0d lfl=%0d err=%b exp all zero",
                     frame_done, frame_cnt, last_line_len, last_frame_lines, err_flags);
        end
        reset_n = 1'b1;
        tick(1);
        checks++;
        if (vif.s_tready !== 1'b1) begin
            failures++; $display("FAIL reset_release_tready got=%b exp=1", vif.s_tready);
        end
    endtask

    task automatic test_clean();
        int fd0;
        do_reset();
        fd0 = fd_total;
        send_frame();
        send_frame();
        tick(3);
        checks++;
        if (fd_total - fd0 !== 2) begin
            failures++; $display("FAIL clean_frame_done got=%0d exp=2", fd_total - fd0);
        end
        checks++;
        if (frame_cnt !== 16'd2) begin
            failures++; $display("FAIL clean_frame_cnt got=%0d exp=2", frame_cnt);
        end
        checks++;
        if (last_line_len !== 16'd8) begin
            failures++; $display("FAIL clean_line_len got=%0d exp=8", last_line_len);
        end
        checks++;
        if (last_frame_lines !== 16'd4) begin
            failures++; $display("FAIL clean_frame_lines got=%0d exp=4", last_frame_lines);
        end
        checks++;
        if (err_flags !== 4'b0000) begin
            failures++; $display("FAIL clean_err got=%b exp=0000", err_flags);
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] seq = '0;
        logic       prev;
        int         mism = 0;
        int         tog = 0;
        int         fd0;
        vif.s_tvalid = 1'b0;
        bp_en   = 1'b1;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        prev    = vif.s_tready;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (i < 6) seq = {seq[4:0], vif.s_tready};
            if (vif.s_tready !== exp_rdy) mism++;
            if (vif.s_tready !== prev) tog++;
            prev = vif.s_tready;
        end
        checks++;
        if (seq !== 6'b100001) begin
            failures++; $display("FAIL bp_first_seq got=%b exp=100001", seq);
        end
        checks++;
        if (mism != 0) begin
            failures++; $display("FAIL bp_lfsr_seq mismatched_cycles=%0d exp=0", mism);
        end
        checks++;
        if (tog < 4) begin
            failures++; $display("FAIL bp_toggle toggles=%0d exp>=4", tog);
        end
        fd0 = fd_total;
        for (int f = 0; f < 3; f++) send_frame();
        tick(3);
        checks++;
        if (frame_cnt !== 16'd3) begin
            failures++; $display("FAIL bp_frame_cnt got=%0d exp=3", frame_cnt);
        end
        checks++;
        if (fd_total - fd0 !== 3) begin
            failures++; $display("FAIL bp_frame_done got=%0d exp=3", fd_total - fd0);
        end
        checks++;
        if (err_flags !== 4'b0000) begin
            failures++; $display("FAIL bp_err got=%b exp=0000", err_flags);
        end
        bp_en = 1'b0;
    endtask

    task automatic test_short_line();
        do_reset();
        send_line(8, 1'b1);
        send_line(8, 1'b0);
        send_line(6, 1'b0);
        checks++;
        if (last_line_len !== 16'd6) begin
            failures++; $display("FAIL short_line_len got=%0d exp=6", last_line_len);
        end
        checks++;
        if (err_flags !== 4'b0001) begin
            failures++; $display("FAIL short_err got=%b exp=0001", err_flags);
        end
        send_line(8, 1'b0);
        tick(2);
        checks++;
        if (frame_cnt !== 16'd1) begin
            failures++; $display("FAIL short_frame_cnt got=%0d exp=1", frame_cnt);
        end
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        checks++;
        if (err_flags !== 4'b0000) begin
            failures++; $display("FAIL short_clr got=%b exp=0000", err_flags);
        end
        // A short line ending on the same edge as clr_err must leave bit 0 set.
        send_line(8, 1'b1);
        for (int i = 0; i < 4; i++) send_beat(1'b0, 1'b0);
        clr_err = 1'b1;
        send_beat(1'b0, 1'b1);
        clr_err = 1'b0;
        checks++;
        if (err_flags !== 4'b0001) begin
            failures++; $display("FAIL short_clr_same_cycle got=%b exp=0001", err_flags);
        end
    endtask

    task automatic test_long_line();
        int fd0;
        do_reset();
        fd0 = fd_total;
        send_line(8, 1'b1);
        send_line(10, 1'b0);
        checks++;
        if (last_line_len !== 16'd10) begin
            failures++; $display("FAIL long_line_len got=%0d exp=10", last_line_len);
        end
        checks++;
        if (err_flags !== 4'b0010) begin
            failures++; $display("FAIL long_err got=%b exp=0010", err_flags);
        end
        send_line(8, 1'b0);
        send_line(8, 1'b0);
        tick(2);
        checks++;
        if (frame_cnt !== 16'd1 || fd_total - fd0 !== 1) begin
            failures++;
            $display("FAIL long_frame_complete got cnt=%0d pulses=%0d exp 1/1", frame_cnt, fd_total - fd0);
        end
        checks++;
        if (last_frame_lines !== 16'd4) begin
            failures++; $display("FAIL long_frame_lines got=%0d exp=4", last_frame_lines);
        end
    endtask

    task automatic test_early_sof();
        int fd0;
        do_reset();
        fd0 = fd_total;
        send_line(8, 1'b1);
        send_line(8, 1'b0);
        send_beat(1'b1, 1'b0);
        checks++;
        if (err_flags !== 4'b0100) begin
            failures++; $display("FAIL early_err got=%b exp=0100", err_flags);
        end
        checks++;
        if (last_frame_lines !== 16'd2) begin
            failures++; $display("FAIL early_frame_lines got=%0d exp=2", last_frame_lines);
        end
        checks++;
        if (frame_cnt !== 16'd0) begin
            failures++; $display("FAIL early_no_count got=%0d exp=0", frame_cnt);
        end
        send_line(7, 1'b0);
        for (int l = 1; l < V; l++) send_line(8, 1'b0);
        tick(2);
        checks++;
        if (frame_cnt !== 16'd1 || fd_total - fd0 !== 1) begin
            failures++;
            $display("FAIL early_clean_frame got cnt=%0d pulses=%0d exp 1/1", frame_cnt, fd_total - fd0);
        end
        checks++;
        if (last_frame_lines !== 16'd4) begin
            failures++; $display("FAIL early_final_lines got=%0d exp=4", last_frame_lines);
        end
    endtask

    task automatic test_reset_mid_line();
        do_reset();
        send_line(8, 1'b1);
        send_beat(1'b1, 1'b0);
        send_beat(1'b0, 1'b0);
        send_beat(1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({vif.s_tready, frame_done, frame_cnt, last_line_len, last_frame_lines, err_flags} !== 54'd0) begin
            failures++;
            $display("FAIL midreset_outputs got rdy=%b fd=%b fc=%0d lll=%0d lfl=%0d err=%b exp all zero",
                     vif.s_tready, frame_done, frame_cnt, last_line_len, last_frame_lines, err_flags);
        end
        tick(1);
        reset_n = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) send_beat(1'b0, 1'b0);
        checks++;
        if (err_flags !== 4'b1000) begin
            failures++; $display("FAIL midreset_sof_missing got=%b exp=1000", err_flags);
        end
        send_frame();
        tick(2);
        checks++;
        if (frame_cnt !== 16'd1) begin
            failures++; $display("FAIL midreset_frame_cnt got=%0d exp=1", frame_cnt);
        end
        checks++;
        if (err_flags !== 4'b1000) begin
            failures++; $display("FAIL midreset_err_sticky got=%b exp=1000", err_flags);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1;
        test_reset();
        test_clean();
        test_backpressure();
        test_short_line();
        test_long_line();
        test_early_sof();
        test_reset_mid_line();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_video_chk.md
AXIS_VIDEO_CHK -- requirements
Module: axis_video_chk

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- H_ACTIVE, 1920, expected beats per line.
- V_ACTIVE, 1080, expected lines per frame.
- DATA_W, 24, tdata width.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk_in, in, 1, the single clock.
- reset_n, in, 1, asynchronous active-low reset.
- s_tdata, in, DATA_W, video pixel data; captured but not checked.
- s_tvalid, in, 1, source beat valid.
- s_tready, out, 1, sink ready.
- s_tuser, in, 1, start of frame; marks the first beat of a frame.
- s_tlast, in, 1, end of line; marks the last beat of a line.
- bp_en, in, 1, 1 = pseudo-random backpressure on s_tready.
- clr_err, in, 1, single-cycle pulse that clears the sticky errors.
- frame_done, out, 1, one-cycle pulse when a complete frame has been accepted.
- frame_cnt, out, 16, count of completed frames; wraps.
- last_line_len, out, 16, beat count of the most recent line.
- last_frame_lines, out, 16, line count of the most recent frame.
- err_flags, out, 4, sticky errors: [0] short line, [1] long line, [2] early SOF, [3] SOF missing.

Function
REQ-003 A beat SHALL be defined as s_tvalid && s_tready on a rising edge of clk_in; no counter or state SHALL change on a cycle without a beat, apart from the LFSR and clr_err.
REQ-004 s_tready SHALL be registered and SHALL NOT depend combinationally on any input.
- bp_en=0: s_tready SHALL be 1.
- bp_en=1: s_tready SHALL be bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 0xACE1) that advances every cycle.
REQ-005 The FSM SHALL have two states, WAIT_SOF (the reset state) and IN_FRAME.
REQ-006 In WAIT_SOF, behaviour SHALL be:
- A beat without tuser SHALL be discarded and SHALL set err_flags[3], once per gap.
- A beat with tuser SHALL enter IN_FRAME with pix_cnt=1 and line_cnt=0.
- If that same beat also has tlast, it SHALL be handled as a line end per REQ-007.
REQ-007 In IN_FRAME, every beat SHALL increment pix_cnt, with these rules:
- A beat with tlast SHALL load last_line_len with pix_cnt+1.
- If pix_cnt+1 < H_ACTIVE on that tlast beat, the block SHALL set err_flags[0].
- A tlast beat SHALL clear pix_cnt and increment line_cnt.
REQ-008 A beat where pix_cnt+1 = H_ACTIVE+1, with no tlast seen yet in the line, SHALL set err_flags[1] once per line. Counting SHALL continue to tlast, saturating at 0xFFFF.
REQ-009 When a tlast beat makes line_cnt reach V_ACTIVE, the block SHALL, on the next cycle:
- pulse frame_done;
- increment frame_cnt, wrapping 0xFFFF -> 0;
- load last_frame_lines with V_ACTIVE;
- return to WAIT_SOF.
REQ-010 A tuser beat in IN_FRAME SHALL set err_flags[2], SHALL load last_frame_lines with the current line_cnt, and SHALL restart the frame with pix_cnt=1 and line_cnt=0, without pulsing frame_done.
REQ-011 err_flags bits SHALL be sticky. clr_err SHALL clear all bits, except that a bit set in the same cycle as clr_err SHALL remain set.
REQ-012 pix_cnt and line_cnt SHALL be 16 bits wide, and all comparisons SHALL be unsigned.

Reset
REQ-013 Asserting reset_n low SHALL immediately, at any point including mid-frame, force these values:
- FSM = WAIT_SOF;
- s_tready = 0;
- LFSR = 0xACE1;
- frame_done = 0;
- frame_cnt, last_line_len, last_frame_lines, err_flags, pix_cnt and line_cnt = 0.
REQ-014 After release, s_tready SHALL rise on the first clk_in edge. No partial frame SHALL be counted across reset.

Structure
REQ-015 The package axis_video_pkg SHALL hold:
- the default H_ACTIVE and V_ACTIVE values;
- the FSM state encoding;
- the err_flags bit indices;
- the LFSR seed and taps.
REQ-016 The LFSR SHALL be the sub-module axis_bp_lfsr, with ports clk_in, reset_n, en, and q[15:0].
REQ-017 The target implementation SHALL be 150-250 lines of RTL.

Verification
REQ-018 With bp_en=0 and H_ACTIVE=8, V_ACTIVE=4, drive 2 clean frames; the bench SHALL see:
- frame_done pulsed twice;
- frame_cnt=2, last_line_len=8, last_frame_lines=4;
- err_flags=0.
REQ-019 With bp_en=1 and a source that holds its beats under backpressure, drive 3 clean frames; the bench SHALL see frame_cnt=3, err_flags=0, and s_tready toggling in the LFSR sequence.
REQ-020 With line 2 ending after 6 beats, the bench SHALL see err_flags[0]=1 and last_line_len=6. After clr_err it SHALL see err_flags=0.
REQ-021 With line 1 running 10 beats, the bench SHALL see err_flags[1]=1 and last_line_len=10, and the frame SHALL still complete.
REQ-022 With tuser injected at line 2 followed by a full clean frame, the bench SHALL see:
- err_flags[2]=1;
- last_frame_lines=2 immediately after the injection;
- frame_cnt=1 and last_frame_lines=4 after the clean frame completes.
REQ-023 With reset_n asserted mid-line and then 3 non-tuser beats followed by a clean frame, the bench SHALL see:
- all outputs at zero during reset;
- err_flags[3]=1;
- frame_cnt=1.
